// File: rtl/zion_riscv_add_sub_decode_if.sv
// Handshake/bus bundle for zion_riscv_add_sub_decode.
// slave: block side (instr/rs data/iValid/iReady in; bundle/oValid/oReady out); master: driver side.
interface zion_riscv_add_sub_decode_if #(
  parameter int RV64 = 0
);
  localparam int XLEN = 32 * (RV64 + 1);

  logic            iValid;
  logic            oReady;
  logic [31:0]     iInstr;
  logic [XLEN-1:0] iRs1Data;
  logic [XLEN-1:0] iRs2Data;
  logic            oValid;
  logic            iReady;
  logic [RV64+1:0] oOp;
  logic [XLEN-1:0] oS1;
  logic [XLEN-1:0] oS2;
  logic            oUnsignedFlg;
  logic [1:0]      oCmpKind;
  logic            oIllegal;

  modport slave (
    input  iValid, iInstr, iRs1Data, iRs2Data, iReady,
    output oReady, oValid, oOp, oS1, oS2,
    output oUnsignedFlg, oCmpKind, oIllegal
  );

  modport master (
    output iValid, iInstr, iRs1Data, iRs2Data, iReady,
    input  oReady, oValid, oOp, oS1, oS2,
    input  oUnsignedFlg, oCmpKind, oIllegal
  );
endinterface

// File: rtl/zion_riscv_add_sub_decode.sv
// Decode-side producer for the shared adder: op/s1/s2 plus compare info.
// Ports: clk, rst (async high), bus (slave modport), 2-entry skid output.
module zion_riscv_add_sub_decode #(
  parameter int RV64 = 0
) (
  input logic clk,
  input logic rst,
  zion_riscv_add_sub_decode_if.slave bus
);
  localparam int XLEN = 32 * (RV64 + 1);
  localparam int OPW  = RV64 + 2;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] s2;
    logic            uns;
    logic [1:0]      cmp;
    logic            ill;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t  state, stateNxt;
  bundle_t dec, outReg, skidReg;
  logic    loadNew, loadSkid, skidToOut;
  logic    accept, deliver;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] immI, immS;
  logic            unusedRs1Field;

  assign opc  = bus.iInstr[6:0];
  assign f3   = bus.iInstr[14:12];
  assign f7   = bus.iInstr[31:25];
  assign immI = {{(XLEN-12){bus.iInstr[31]}}, bus.iInstr[31:20]};
  assign immS = {{(XLEN-12){bus.iInstr[31]}},
                 bus.iInstr[31:25], bus.iInstr[11:7]};
  assign unusedRs1Field = ^bus.iInstr[19:15];

  logic isR, isI, isLd, isSt, isBr, isRw, isIw, rv64;
  assign rv64 = (RV64 != 0);
  assign isR  = opc == 7'b0110011;
  assign isI  = opc == 7'b0010011;
  assign isLd = opc == 7'b0000011;
  assign isSt = opc == 7'b0100011;
  assign isBr = opc == 7'b1100011;
  assign isRw = rv64 && opc == 7'b0111011;
  assign isIw = rv64 && opc == 7'b0011011;

  logic rAdd, rSub, rSlt, iAdd, iSlt, ld, st;
  logic bLt, bGe, wAdd, wSub, wAddi, ldF3, stF3;
  assign ldF3 = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                f3 == 3'd4 || f3 == 3'd5 ||
                (rv64 && (f3 == 3'd3 || f3 == 3'd6));
  assign stF3 = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                (rv64 && f3 == 3'd3);
  assign rAdd  = isR && f3 == 3'd0 && f7 == 7'h00;
  assign rSub  = isR && f3 == 3'd0 && f7 == 7'h20;
  assign rSlt  = isR && f3[2:1] == 2'b01 && f7 == 7'h00;
  assign iAdd  = isI && f3 == 3'd0;
  assign iSlt  = isI && f3[2:1] == 2'b01;
  assign ld    = isLd && ldF3;
  assign st    = isSt && stF3;
  assign bLt   = isBr && f3[2] && !f3[0];
  assign bGe   = isBr && f3[2] && f3[0];
  assign wAdd  = isRw && f3 == 3'd0 && f7 == 7'h00;
  assign wSub  = isRw && f3 == 3'd0 && f7 == 7'h20;
  assign wAddi = isIw && f3 == 3'd0;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      rAdd, wAdd: begin
        dec.op[0] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = bus.iRs2Data;
      end
      rSub, wSub: begin
        dec.op[1] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = bus.iRs2Data;
      end
      iAdd, ld, wAddi: begin
        dec.op[0] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = immI;
      end
      st: begin
        dec.op[0] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = immS;
      end
      bLt, bGe: begin
        dec.op[1] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = bus.iRs2Data;
        dec.cmp   = bLt ? 2'b01 : 2'b10;
        dec.uns   = f3[1];
      end
      rSlt: begin
        dec.op[1] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = bus.iRs2Data;
        dec.cmp   = 2'b11;
        dec.uns   = f3[0];
      end
      iSlt: begin
        // SLTIU keeps the sign-extended immediate, compared unsigned
        dec.op[1] = 1'b1;
        dec.s1    = bus.iRs1Data;
        dec.s2    = immI;
        dec.cmp   = 2'b11;
        dec.uns   = f3[0];
      end
      default: dec.ill = 1'b1;
    endcase
    // .W flags are only reachable when RV64, so op[OPW-1] is op[2]
    if (wAdd || wSub || wAddi) dec.op[OPW-1] = 1'b1;
  end

  assign accept  = bus.iValid & bus.oReady;
  assign deliver = bus.oValid & bus.iReady;

  always_comb begin
    stateNxt  = state;
    loadNew   = 1'b0;
    loadSkid  = 1'b0;
    skidToOut = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        stateNxt = ONE;
        loadNew  = 1'b1;
      end
      ONE: begin
        if (accept && !deliver) begin
          stateNxt = TWO;
          loadSkid = 1'b1;
        end else if (deliver && !accept) begin
          stateNxt = EMPTY;
        end else if (accept && deliver) begin
          loadNew = 1'b1;
        end
      end
      TWO: if (deliver) begin
        stateNxt  = ONE;
        skidToOut = 1'b1;
      end
      default: stateNxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      outReg  <= '0;
      skidReg <= '0;
    end else begin
      state <= stateNxt;
      if (loadNew)   outReg  <= dec;
      if (skidToOut) outReg  <= skidReg;
      if (loadSkid)  skidReg <= dec;
    end
  end

  assign bus.oValid       = state != EMPTY;
  assign bus.oReady       = state != TWO;
  assign bus.oOp          = outReg.op;
  assign bus.oS1          = outReg.s1;
  assign bus.oS2          = outReg.s2;
  assign bus.oUnsignedFlg = outReg.uns;
  assign bus.oCmpKind     = outReg.cmp;
  assign bus.oIllegal     = outReg.ill;
endmodule

// File: doc/zion_riscv_add_sub_decode.md
Name: zion_riscv_add_sub_decode

Overview:
- Decode-side producer for the add/sub execution interface. Drives op/s1/s2 for every instruction class that uses the shared adder: ADD/SUB family, load/store address, branch compare, SLT family.
- Accepts decoded-stage inputs: instruction word plus register-file read data.
- Outputs pass through a 2-entry skid-buffered pipeline register with valid/ready on both sides.
- Also supplies the unsigned flag and compare kind that the less-than logic consumes downstream.

Parameters:
RV64, 0, 1 = RV64I core (XLEN=64, .W ops legal); 0 = RV32I (XLEN=32)
XLEN, 32*(RV64+1), derived; not overridable

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
iValid  input  1  upstream instruction valid
oReady  output  1  block can accept an instruction this cycle
iInstr  input  32  RISC-V instruction word
iRs1Data  input  XLEN  rs1 read data
iRs2Data  input  XLEN  rs2 read data
oValid  output  1  output bundle valid
iReady  input  1  execution side accepts bundle
oOp  output  RV64+2  [0]=add, [1]=sub, [2]=.W (RV64 only)
oS1  output  XLEN  adder operand 1
oS2  output  XLEN  adder operand 2
oUnsignedFlg  output  1  compare is unsigned (BLTU/BGEU/SLTU/SLTIU)
oCmpKind  output  2  00 none, 01 branch-LT, 10 branch-GE, 11 set-less-than
oIllegal  output  1  instruction is not an adder-class instruction

Behaviour:
- Reset: state EMPTY; oValid=0, oReady=1; oOp, oS1, oS2, oUnsignedFlg, oCmpKind, oIllegal all 0. Reset asserted mid-operation discards both entries immediately.
- Handshakes: accept = iValid & oReady; deliver = oValid & iReady.
- Output bundle is registered. Latency is 1 cycle from accept to oValid.
- While oValid=1 and iReady=0, every output holds stable.
- State machine (entries held):
  - EMPTY: accept -> ONE.
  - ONE: accept & !deliver -> TWO (new bundle goes to the skid register). deliver & !accept -> EMPTY. Both -> ONE, with the output register loaded with the new bundle.
  - TWO: oReady=0. deliver -> ONE, skid register moves to the output register.
- oReady is registered: 1 in EMPTY and ONE, 0 in TWO. Full throughput holds when iReady=1.
- Decode rules (opcode / funct3 / funct7):
  - ADD (funct7=0x00): op=add, s1=rs1, s2=rs2.
  - SUB (funct7=0x20): op=sub, s1=rs1, s2=rs2.
  - ADDI: op=add, s2=sext(I-imm).
  - LOAD (I-imm) and STORE (S-imm): op=add, s1=rs1, s2=sext(imm).
  - BLT/BGE/BLTU/BGEU: op=sub, s1=rs1, s2=rs2. cmpKind=01 (LT) or 10 (GE). unsigned flag set for the U forms.
  - SLT/SLTU: op=sub, s1=rs1, s2=rs2, cmpKind=11.
  - SLTI/SLTIU: op=sub, s2=sext(I-imm), cmpKind=11. SLTIU compares against the sign-extended immediate, treated as unsigned.
  - RV64 only: ADDW/SUBW/ADDIW set op[2] together with add/sub.
- Illegal cases: any other opcode/funct combination, BEQ/BNE, or .W ops when RV64=0. These set oIllegal=1, op=0, s1=s2=0, cmpKind=00, and still flow through the handshake.
- At most one of op[0]/op[1] is ever 1.
- Immediates are sign-extended to XLEN before registering.

Test Plan:
- Reset then ADD x1,x2,x3 with rs1=5, rs2=7, iReady=1 -> next cycle oValid=1, oOp[1:0]=01, oS1=5, oS2=7, oIllegal=0; following cycle oValid=0.
- ADDI with imm=-1 (0xFFF), rs1=0x10 -> oS2=0xFFFFFFFF (RV32), op=add.
- BLTU with rs1=1, rs2=0xFFFFFFFF -> op=sub, oUnsignedFlg=1, oCmpKind=01.
- Backpressure: iReady=0, issue 3 back-to-back ADDs with distinct rs1=1,2,3:
  - 2 accepted; oReady=0 from the cycle after the 2nd accept.
  - outputs hold rs1=1.
  - raise iReady -> bundles 1,2 delivered in order, then bundle 3 accepted.
- RV64=1, ADDW -> oOp=101. RV64=0, same instruction -> oIllegal=1, oOp=00.
- Assert rst while state TWO -> oValid=0, oReady=1 in the same cycle (asynchronous); no stale bundle appears after reset release.
